// File: rtl/time_entry_pkg.sv
// time_entry_pkg: shared state type and sizing constants for the time entry block
package time_entry_pkg;
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, LOAD} state_t;
  localparam int DIGIT_W = 4;
  localparam int MAX_DIGITS = 3;
  localparam int MAX_TENS = 5;
endpackage

// File: rtl/time_entry_key_edge.sv
// key_edge: registered rising-edge detector on the keypad strobe, history reset to 1
module key_edge (
  input  logic clk,
  input  logic clearn,
  input  logic i_key_valid,
  output logic o_rise
);
  logic r_prev;
  // history resets high so a key held through reset is never taken as a fresh press
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) r_prev <= 1'b1;
    else r_prev <= i_key_valid;
  assign o_rise = i_key_valid & ~r_prev;
endmodule

// File: rtl/time_entry.sv
// time_entry: keypad digit entry feeding a mod-6/mod-10 counter chain; TENS_LIMIT_EN caps seconds-tens at 5
module time_entry
  import time_entry_pkg::*;
(
  input  logic               clk,
  input  logic               clearn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               start,
  input  logic               cancel,
  input  logic               counting,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic               load_n,
  output logic [1:0]         digit_cnt,
  output logic               key_err
);
  state_t r_state, w_next;
  logic [DIGIT_W-1:0] r_ones, r_tens, r_min, w_ones, w_tens, w_min;
  logic [1:0] r_cnt, w_cnt;
  logic r_load_n, r_err, w_err, w_rise, w_bad, w_tens_bad;

  key_edge u_key_edge (.clk(clk), .clearn(clearn), .i_key_valid(key_valid), .o_rise(w_rise));

`ifdef TENS_LIMIT_EN
  assign w_tens_bad = r_ones > DIGIT_W'(MAX_TENS);
`else
  assign w_tens_bad = 1'b0;
`endif
  assign w_bad = (key_code > 4'd9) || (r_state == FULL) || counting || w_tens_bad;

  // next state and digit shift; LOAD always drains, cancel beats start, start beats a key
  always_comb begin
    w_next = r_state;
    w_ones = r_ones;
    w_tens = r_tens;
    w_min  = r_min;
    w_cnt  = r_cnt;
    w_err  = 1'b0;
    if (r_state == LOAD || cancel) begin
      w_next = EMPTY;
      w_ones = '0;
      w_tens = '0;
      w_min  = '0;
      w_cnt  = '0;
      w_err  = (r_state == LOAD) && w_rise;
    end else if (start && !counting && r_state != EMPTY) begin
      w_next = LOAD;
    end else if (w_rise) begin
      if (w_bad) begin
        w_err = 1'b1;
      end else begin
        w_min  = r_tens;
        w_tens = r_ones;
        w_ones = key_code;
        w_cnt  = r_cnt + 2'd1;
        w_next = (r_cnt == 2'(MAX_DIGITS - 1)) ? FULL : ENTRY;
      end
    end
  end

  // state, digits and registered strobes; reset aborts any load in progress
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) begin
      r_state  <= EMPTY;
      r_ones   <= '0;
      r_tens   <= '0;
      r_min    <= '0;
      r_cnt    <= '0;
      r_load_n <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ones   <= w_ones;
      r_tens   <= w_tens;
      r_min    <= w_min;
      r_cnt    <= w_cnt;
      r_load_n <= (w_next != LOAD);
      r_err    <= w_err;
    end

  assign sec_ones  = r_ones;
  assign sec_tens  = r_tens;
  assign min_ones  = r_min;
  assign digit_cnt = r_cnt;
  assign load_n    = r_load_n;
  assign key_err   = r_err;
endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: directed scenarios plus randomized run against a queue-based reference model
module tb_time_entry;
  logic clk = 1'b0, clearn = 1'b0, key_valid = 1'b0, start = 1'b0, cancel = 1'b0, counting = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic load_n, key_err;
  logic [1:0] digit_cnt;
  int errors = 0, checks = 0;
  int m_q[$];
  bit m_load, m_prev, m_err;
  logic last_err;

  time_entry dut (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .cancel(cancel), .counting(counting),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .load_n(load_n), .digit_cnt(digit_cnt), .key_err(key_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q.delete();
    m_load = 1'b0;
    m_prev = 1'b1;
    m_err = 1'b0;
  endfunction

  // one clock of the entry rules expressed on a queue of accepted digits
  function automatic void model_edge();
    bit rise, ok;
    rise = key_valid && !m_prev;
    m_prev = key_valid;
    m_err = 1'b0;
    if (m_load) begin
      m_load = 1'b0;
      m_q.delete();
      m_err = rise;
    end else if (cancel) begin
      m_q.delete();
    end else if (start && !counting && m_q.size() > 0) begin
      m_load = 1'b1;
    end else if (rise) begin
      ok = key_code <= 9 && m_q.size() < 3 && !counting;
`ifdef TENS_LIMIT_EN
      if (m_q.size() > 0 && m_q[m_q.size()-1] > 5) ok = 1'b0;
`endif
      if (ok) m_q.push_back(int'(key_code));
      else m_err = 1'b1;
    end
  endfunction

  function automatic int exp_ones();
    return m_q.size() >= 1 ? m_q[m_q.size()-1] : 0;
  endfunction
  function automatic int exp_tens();
    return m_q.size() >= 2 ? m_q[m_q.size()-2] : 0;
  endfunction
  function automatic int exp_min();
    return m_q.size() >= 3 ? m_q[0] : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code = code;
    step();
    last_err = key_err;
    key_valid = 1'b0;
    step();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    clearn = 1'b0;
    key_valid = 1'b1;
    key_code = 4'd6;
    model_reset();
    #12;
    checks++;
    if ({min_ones, sec_tens, sec_ones, digit_cnt, load_n, key_err} !== {4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", {min_ones, sec_tens, sec_ones, digit_cnt, load_n, key_err}, {4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    clearn = 1'b1;
    step();
    checks++;
    if (digit_cnt !== 2'd0 || key_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_key: got cnt=%0d err=%b required cnt=0 err=0", digit_cnt, key_err);
    end
    key_valid = 1'b0;
    step();
  endtask

  task automatic test_load();
    press(4'd1);
    press(4'd3);
    press(4'd0);
    checks++;
    if ({min_ones, sec_tens, sec_ones, digit_cnt} !== {4'd1, 4'd3, 4'd0, 2'd3}) begin
      errors++;
      $display("FAIL load_digits: got %0d%0d%0d cnt=%0d required 130 cnt=3", min_ones, sec_tens, sec_ones, digit_cnt);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (load_n !== 1'b0 || {min_ones, sec_tens, sec_ones} !== {4'd1, 4'd3, 4'd0}) begin
      errors++;
      $display("FAIL load_strobe: got load_n=%b digits=%0d%0d%0d required load_n=0 digits=130", load_n, min_ones, sec_tens, sec_ones);
    end
    step();
    checks++;
    if ({load_n, min_ones, sec_tens, sec_ones, digit_cnt} !== {1'b1, 4'd0, 4'd0, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL load_after: got load_n=%b digits=%0d%0d%0d cnt=%0d required 1 000 0", load_n, min_ones, sec_tens, sec_ones, digit_cnt);
    end
  endtask

  task automatic test_tens_limit();
    press(4'd1);
    press(4'd7);
    press(4'd5);
`ifdef TENS_LIMIT_EN
    checks++;
    if (last_err !== 1'b1 || key_err !== 1'b0) begin
      errors++;
      $display("FAIL tens_err_pulse: got %b then %b required 1 then 0", last_err, key_err);
    end
    checks++;
    if ({sec_tens, sec_ones, digit_cnt} !== {4'd1, 4'd7, 2'd2}) begin
      errors++;
      $display("FAIL tens_retained: got tens=%0d ones=%0d cnt=%0d required 1 7 2", sec_tens, sec_ones, digit_cnt);
    end
`else
    checks++;
    if (last_err !== 1'b0) begin
      errors++;
      $display("FAIL tens_no_err: got %b required 0", last_err);
    end
    checks++;
    if ({min_ones, sec_tens, sec_ones, digit_cnt} !== {4'd1, 4'd7, 4'd5, 2'd3}) begin
      errors++;
      $display("FAIL tens_unchecked: got %0d%0d%0d cnt=%0d required 175 cnt=3", min_ones, sec_tens, sec_ones, digit_cnt);
    end
`endif
    do_cancel();
    checks++;
    if ({min_ones, sec_tens, sec_ones, digit_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL cancel_clear: got %0d%0d%0d cnt=%0d required all 0", min_ones, sec_tens, sec_ones, digit_cnt);
    end
  endtask

  task automatic test_hold();
    int errs = 0;
    key_valid = 1'b1;
    key_code = 4'd4;
    for (int i = 0; i < 5; i++) begin
      step();
      errs += int'(key_err);
    end
    key_valid = 1'b0;
    step();
    checks++;
    if (sec_ones !== 4'd4 || digit_cnt !== 2'd1 || errs != 0) begin
      errors++;
      $display("FAIL hold_once: got ones=%0d cnt=%0d errs=%0d required 4 1 0", sec_ones, digit_cnt, errs);
    end
    do_cancel();
  endtask

  task automatic test_reject();
    press(4'd2);
    press(4'd1);
    press(4'd4);
    press(4'd3);
    checks++;
    if (last_err !== 1'b1) begin
      errors++;
      $display("FAIL full_reject: got err=%b required 1", last_err);
    end
    press(4'd12);
    checks++;
    if (last_err !== 1'b1) begin
      errors++;
      $display("FAIL code12_reject: got err=%b required 1", last_err);
    end
    checks++;
    if ({min_ones, sec_tens, sec_ones, digit_cnt, key_err} !== {4'd2, 4'd1, 4'd4, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL full_kept: got %0d%0d%0d cnt=%0d err=%b required 214 cnt=3 err=0", min_ones, sec_tens, sec_ones, digit_cnt, key_err);
    end
    do_cancel();
  endtask

  task automatic test_start_cancel();
    press(4'd5);
    start = 1'b1;
    cancel = 1'b1;
    step();
    start = 1'b0;
    cancel = 1'b0;
    checks++;
    if (load_n !== 1'b1 || digit_cnt !== 2'd0 || sec_ones !== 4'd0) begin
      errors++;
      $display("FAIL cancel_over_start: got load_n=%b cnt=%0d ones=%0d required 1 0 0", load_n, digit_cnt, sec_ones);
    end
    step();
    checks++;
    if (load_n !== 1'b1) begin
      errors++;
      $display("FAIL cancel_no_load: got load_n=%b required 1", load_n);
    end
    press(4'd5);
    counting = 1'b1;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    counting = 1'b0;
    checks++;
    if (load_n !== 1'b1 || digit_cnt !== 2'd1 || key_err !== 1'b0) begin
      errors++;
      $display("FAIL start_counting: got load_n=%b cnt=%0d err=%b required 1 1 0", load_n, digit_cnt, key_err);
    end
    do_cancel();
  endtask

  task automatic test_async_reset();
    press(4'd1);
    press(4'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (load_n !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort_load: got load_n=%b required 0", load_n);
    end
    #1 clearn = 1'b0;
    #1;
    checks++;
    if ({load_n, min_ones, sec_tens, sec_ones, digit_cnt, key_err} !== {1'b1, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_load: got load_n=%b digits=%0d%0d%0d cnt=%0d err=%b required 1 000 0 0", load_n, min_ones, sec_tens, sec_ones, digit_cnt, key_err);
    end
    model_reset();
    @(negedge clk);
    clearn = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) key_valid = ~key_valid;
      key_code = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      start = $urandom_range(0, 9) == 0;
      cancel = $urandom_range(0, 19) == 0;
      counting = $urandom_range(0, 7) == 0;
      step();
      checks++;
      if ({int'(min_ones), int'(sec_tens), int'(sec_ones), int'(digit_cnt)} !== {exp_min(), exp_tens(), exp_ones(), m_q.size()}) begin
        errors++;
        $display("FAIL rand_digits cyc %0d: got %0d%0d%0d cnt=%0d required %0d%0d%0d cnt=%0d", i, min_ones, sec_tens, sec_ones, digit_cnt, exp_min(), exp_tens(), exp_ones(), m_q.size());
      end
      checks++;
      if (load_n !== !m_load || key_err !== m_err) begin
        errors++;
        $display("FAIL rand_strobes cyc %0d: got load_n=%b err=%b required load_n=%b err=%b", i, load_n, key_err, !m_load, m_err);
      end
    end
    key_valid = 1'b0;
    start = 1'b0;
    cancel = 1'b0;
    counting = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_tens_limit();
    test_hold();
    test_reject();
    test_start_cancel();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 The module SHALL have these ports: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have these ports: clearn, input, 1 bit, asynchronous active-low reset.
REQ-003 The module SHALL have these ports: key_valid, input, 1 bit, keypad strobe, level-held by the source for at least 1 cycle.
REQ-004 The module SHALL have these ports: key_code, input, 4 bits, BCD digit 0-9; codes 10-15 are invalid.
REQ-005 The module SHALL have these ports: start, input, 1 bit, request to load the entered time into the counter chain.
REQ-006 The module SHALL have these ports: cancel, input, 1 bit, discard the entered digits.
REQ-007 The module SHALL have these ports: counting, input, 1 bit, high while the downstream mod-6/mod-10 down-counter chain is enabled.
REQ-008 The module SHALL have these ports: sec_ones, sec_tens and min_ones, outputs, 4 bits each, registered BCD data for the counter chain's data inputs.
REQ-009 The module SHALL have these ports: load_n, output, 1 bit, active-low load strobe to the counters.
REQ-010 The module SHALL have these ports: digit_cnt, output, 2 bits, number of digits held (0-3).
REQ-011 The module SHALL have these ports: key_err, output, 1 bit, 1-cycle pulse when a key is rejected.

Function
REQ-012 Each key SHALL be accepted once, on the first cycle key_valid is high after being low (rising-edge detect).
REQ-013 On an accepted digit, the digits SHALL shift left: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code, digit_cnt+1, all in the same cycle.
REQ-014 The FSM SHALL use the states EMPTY, ENTRY, FULL and LOAD; reset state EMPTY.
REQ-015 EMPTY->ENTRY SHALL occur on the first accepted digit.
REQ-016 ENTRY->FULL SHALL occur when digit_cnt reaches 3.
REQ-017 ENTRY/FULL->LOAD SHALL occur on start while counting=0.
REQ-018 LOAD->EMPTY SHALL occur unconditionally after exactly 1 cycle.
REQ-019 load_n SHALL be 0 only during LOAD (exactly 1 cycle) and 1 otherwise; the digit outputs SHALL be stable during and 1 cycle before LOAD.
REQ-020 On entry to EMPTY from LOAD, the digit registers and digit_cnt SHALL clear to 0.
REQ-021 A key SHALL be rejected, with key_err pulsed 1 cycle and no state change, when any of the following holds: key_code>9; the state is FULL; the state is LOAD; counting=1.
REQ-022 start in EMPTY, or with counting=1, SHALL be ignored with no key_err.
REQ-023 cancel SHALL return the FSM to EMPTY and clear the digits in 1 cycle from ENTRY or FULL.
REQ-024 cancel SHALL have priority over start and key events in the same cycle.
REQ-025 cancel SHALL be ignored during LOAD.
REQ-026 When start and an accepted key occur in the same cycle, the key SHALL be discarded and start SHALL be processed.

Reset
REQ-027 clearn low SHALL immediately force, independent of clk: state EMPTY, all digits 0, digit_cnt 0, load_n 1, key_err 0, and the edge-detect register 1 (a key held through reset is not accepted).
REQ-028 Reset asserted during LOAD SHALL abort the load, with load_n returning to 1 asynchronously.

Configuration
REQ-029 Macro TENS_LIMIT_EN SHALL select whether the seconds-tens limit is enforced.
REQ-030 With TENS_LIMIT_EN defined, a digit SHALL be rejected, with key_err, if the shift would place a value >5 into sec_tens, so the mod-6 stage never receives 6-9.
REQ-031 Without TENS_LIMIT_EN, any BCD digit SHALL shift in unchecked.

Structure
REQ-032 A shared package SHALL hold the state typedef (EMPTY/ENTRY/FULL/LOAD), DIGIT_W=4, MAX_DIGITS=3 and MAX_TENS=5.
REQ-033 One sub-module SHALL be used: key_edge, a registered rising-edge detector on key_valid, reset to 1.

Verification
REQ-034 Bench scenario: keys 1,3,0 then start -> min_ones=1, sec_tens=3, sec_ones=0, digit_cnt=3, then load_n low for exactly 1 cycle, then all 0.
REQ-035 Bench scenario: with TENS_LIMIT_EN, keys 1,7 then 5 -> the third key is rejected (key_err 1 cycle); sec_tens=1, sec_ones=7 retained; without the macro -> 1,7,5 accepted.
REQ-036 Bench scenario: key_valid held high for 5 cycles with code 4 -> exactly one digit accepted (sec_ones=4, digit_cnt=1).
REQ-037 Bench scenario: 4 keys, then key code 12 -> 4th and code-12 keys each give key_err; state FULL unchanged.
REQ-038 Bench scenario: start and cancel in the same cycle from ENTRY -> EMPTY, load_n stays 1; start with counting=1 -> ignored.
REQ-039 Bench scenario: clearn pulsed low mid-LOAD -> load_n returns to 1 before the next edge; all outputs 0.
